// File: rtl/apb_fpu_slave.sv
// APB register slave for the floating-point add/sub co-processor.
// Bus signals are sampled only on apb_edge cycles; everything runs on system_clk.
module apb_fpu_slave #(
    parameter int ADDR_W = 5,
    parameter int FLAG_W = 4
) (
    input  logic              system_clk,
    input  logic              nrst,
    input  logic              apb_edge,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [31:0]       op_a,
    output logic [31:0]       op_b,
    output logic              op_sel,
    output logic              start,
    input  logic              core_done,
    input  logic [31:0]       core_result,
    input  logic [FLAG_W-1:0] core_flags
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [2:0] REG_OPA    = 3'd0;
    localparam logic [2:0] REG_OPB    = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_RESULT = 3'd4;

    function automatic logic rd_legal(input logic [2:0] a);
        return (a <= REG_RESULT);
    endfunction

    // Writable registers are locked while an operation is in flight.
    function automatic logic wr_legal(input logic [2:0] a, input logic busy);
        return (a <= REG_CTRL) && !busy;
    endfunction

    state_t            state_q,   state_d;
    logic [2:0]        addr_q,    addr_d;
    logic              write_q,   write_d;
    logic [31:0]       wdata_q,   wdata_d;
    logic [31:0]       prdata_q,  prdata_d;
    logic              pslverr_q, pslverr_d;
    logic [31:0]       op_a_q,    op_a_d;
    logic [31:0]       op_b_q,    op_b_d;
    logic              op_sel_q,  op_sel_d;
    logic              start_q,   start_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic [31:0]       result_q,  result_d;
    logic [FLAG_W-1:0] flags_q,   flags_d;

    logic [2:0]        setup_addr_s;
    logic [31:0]       rd_val_s;
    logic [31:0]       status_s;
    logic              unused_s;

    assign setup_addr_s = paddr[4:2];
    assign unused_s     = ^paddr[1:0];

    // STATUS word assembled from live busy/done/flags.
    always_comb begin
        status_s              = 32'h0000_0000;
        status_s[0]           = busy_q;
        status_s[1]           = done_q;
        status_s[4 +: FLAG_W] = flags_q;
    end

    // Read mux for the address presented in the setup phase.
    always_comb begin
        case (setup_addr_s)
            REG_OPA:    rd_val_s = op_a_q;
            REG_OPB:    rd_val_s = op_b_q;
            REG_CTRL:   rd_val_s = {31'h0000_0000, op_sel_q};
            REG_STATUS: rd_val_s = status_s;
            REG_RESULT: rd_val_s = result_q;
            default:    rd_val_s = 32'h0000_0000;
        endcase
    end

    // Next-state logic: transfer FSM, register commits, launch and completion.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_sel_d  = op_sel_q;
        start_d   = 1'b0;
        busy_d    = busy_q;
        done_d    = done_q;
        result_d  = result_q;
        flags_d   = flags_q;

        case (state_q)
            IDLE: begin
                if (apb_edge && psel && !penable) begin
                    state_d = ACCESS;
                    addr_d  = setup_addr_s;
                    write_d = pwrite;
                    wdata_d = pwdata;
                    if (pwrite) begin
                        prdata_d  = 32'h0000_0000;
                        pslverr_d = !wr_legal(setup_addr_s, busy_q);
                    end else begin
                        prdata_d  = rd_val_s;
                        pslverr_d = !rd_legal(setup_addr_s);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (apb_edge) begin
                    state_d = IDLE;
                    // Illegal transfers and aborted ones leave all state untouched.
                    if (psel && penable && !pslverr_q) begin
                        if (write_q) begin
                            case (addr_q)
                                REG_OPA: op_a_d = wdata_q;
                                REG_OPB: op_b_d = wdata_q;
                                REG_CTRL: begin
                                    op_sel_d = wdata_q[0];
                                    if (wdata_q[1]) begin
                                        start_d = 1'b1;
                                        busy_d  = 1'b1;
                                        done_d  = 1'b0;
                                    end else begin
                                        start_d = 1'b0;
                                    end
                                end
                                default: op_a_d = op_a_q;
                            endcase
                        end else if (addr_q == REG_STATUS) begin
                            done_d = 1'b0;
                        end else begin
                            done_d = done_q;
                        end
                    end else begin
                        done_d = done_q;
                    end
                end else begin
                    state_d = ACCESS;
                end
            end
            default: state_d = IDLE;
        endcase

        // Completion is applied last so it wins over a same-cycle STATUS clear.
        if (core_done && busy_q) begin
            result_d = core_result;
            flags_d  = core_flags;
            done_d   = 1'b1;
            busy_d   = 1'b0;
        end else begin
            result_d = result_d;
        end
    end

    // State and output registers.
    always_ff @(posedge system_clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            addr_q    <= 3'd0;
            write_q   <= 1'b0;
            wdata_q   <= 32'h0000_0000;
            prdata_q  <= 32'h0000_0000;
            pslverr_q <= 1'b0;
            op_a_q    <= 32'h0000_0000;
            op_b_q    <= 32'h0000_0000;
            op_sel_q  <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= 32'h0000_0000;
            flags_q   <= {FLAG_W{1'b0}};
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_sel_q  <= op_sel_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
        end
    end

    assign prdata  = prdata_q;
    assign pready  = 1'b1;
    assign pslverr = pslverr_q;
    assign op_a    = op_a_q;
    assign op_b    = op_b_q;
    assign op_sel  = op_sel_q;
    assign start   = start_q;

endmodule

// File: doc/apb_fpu_slave.md
Name: apb_fpu_slave

Overview:
- Downstream consumer of the APB edge detector's one-cycle `rising_edge_found` pulse. That pulse arrives on the `apb_edge` input of this block.
- Zero-wait APB slave running entirely in the system_clk domain. APB bus signals are sampled only on cycles where apb_edge=1.
- Holds the operand, control, status and result registers of the floating-point add/sub co-processor, and launches and collects core operations.

Parameters:
ADDR_W, 5, width of paddr; only paddr[4:2] decoded, paddr[1:0] ignored
FLAG_W, 4, width of core exception flags (overflow, underflow, inexact, invalid)

Ports:
system_clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
apb_edge  input  1  one-cycle pulse per detected APB clock rising edge
psel  input  1  APB select
penable  input  1  APB enable
pwrite  input  1  APB write (1) / read (0)
paddr  input  ADDR_W  APB byte address
pwdata  input  32  APB write data
prdata  output  32  APB read data
pready  output  1  constant 1 (zero-wait slave)
pslverr  output  1  APB error response
op_a  output  32  operand A to core
op_b  output  32  operand B to core
op_sel  output  1  0=add, 1=subtract
start  output  1  one-cycle launch pulse to core
core_done  input  1  one-cycle completion pulse from core
core_result  input  32  core result, valid with core_done
core_flags  input  FLAG_W  core flags, valid with core_done

Behaviour:
- Reset (nrst=0, asynchronous): prdata=0, pslverr=0, start=0, op_a=0, op_b=0, op_sel=0. Internal state: busy=0, done=0, result=0, flags=0, FSM=IDLE. pready is always 1.
- Register map (paddr[4:2]):
  - 0 OPA (RW)
  - 1 OPB (RW)
  - 2 CTRL (RW): bit0 op_sel; bit1 start, write-1 self-clears, always reads 0
  - 3 STATUS (RO): bit0 busy; bit1 done; bits[4+FLAG_W-1:4] flags; other bits 0
  - 4 RESULT (RO)
  - 5-7 unmapped
- FSM states IDLE, ACCESS. All transitions occur only on cycles with apb_edge=1; with apb_edge=0 the state is held.
  - IDLE, psel=1 and penable=0 (setup sampled):
    - Latch addr, pwrite and pwdata; go to ACCESS.
    - Next cycle: prdata = decoded read value (0 on writes or unmapped addresses).
    - Next cycle: pslverr = 1 if the access is illegal, else 0.
  - ACCESS, psel=1 and penable=1 (access completes):
    - A legal write commits in this cycle.
    - A STATUS read clears done in this cycle.
    - Go to IDLE.
    - A setup phase sampled on a later edge starts a new transfer (back-to-back supported).
  - ACCESS, psel=0 or penable=0: abort to IDLE, no write, no side effect.
  - IDLE, psel=0: stay in IDLE. IDLE with penable=1 but no prior setup is ignored.
- prdata and pslverr hold their values until the next setup sample.
- Illegal accesses (pslverr=1, no state change):
  - Write to STATUS, RESULT or an unmapped address.
  - Read of an unmapped address.
  - Write to OPA, OPB or CTRL while busy=1. Busy is evaluated at setup sample.
- Launch: a legal CTRL write with pwdata[1]=1, in the commit cycle, updates op_sel. On the following cycle, start=1 for exactly one cycle, busy=1 and done=0.
- Completion: core_done=1 captures core_result and core_flags into result and flags, sets done=1 and clears busy=0 in the same cycle.
- core_done coinciding with a STATUS-read clear: set wins, done=1.
- core_done while busy=0: ignored.
- prdata is a snapshot taken at setup. A completion landing between setup and access does not alter data already presented.
- Reset mid-transfer or mid-operation: immediately return to all reset values. A later core_done is ignored because busy=0.

Test Plan:
- Reset, then read STATUS via setup/access edges -> prdata=0x0, pslverr=0; all outputs 0 during and after reset.
- Write OPA=0x3F800000, OPB=0x40000000, CTRL=0x3 -> op_a/op_b hold the values; op_sel=1; exactly one start pulse one system_clk after CTRL commit; STATUS reads 0x1.
- Pulse core_done with core_result=0xBF800000, core_flags=0x4 -> RESULT reads 0xBF800000. First STATUS read = 0x42; second STATUS read = 0x40.
- While busy, write OPA=0x12345678 -> pslverr=1, op_a unchanged. Write to RESULT and read addr 0x1C -> pslverr=1, prdata=0.
- Setup sampled, then psel dropped before access edge, on a CTRL write with start -> no start pulse, no register change, FSM back in IDLE. Repeat with apb_edge gaps of 1 to 7 cycles -> identical results.
- core_done in the same cycle as a STATUS-read commit -> done remains 1. Assert nrst mid-operation -> busy=0; subsequent core_done leaves RESULT=0.
